// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the five-stage RV32I pipeline.
//
// Holds the 32x32 register file, the immediate generator, the operand-select
// mux (forwarding unit data, write-through bypass or array), and the ID/EX
// pipeline register.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   if_valid_i/if_inst_i/if_pc_i  instruction from fetch
//   id_ready_o                    instruction consumed this cycle
//   rs1_o, rs2_o                  source indices to the forwarding unit (comb)
//   is_fwd_*_i, dat_fwd_*_i       forwarding select and data per operand
//   fwd_stall_i, ex_stall_i       load-use stall, downstream hold
//   flush_i                       kill the instruction in ID
//   wb_we_i/wb_rd_i/wb_dat_i      register-file write port
//   ex_*_o                        ID/EX register contents
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_valid_i,
  input  logic [31:0] if_inst_i,
  input  logic [31:0] if_pc_i,
  output logic        id_ready_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  input  logic        is_fwd_a_i,
  input  logic        is_fwd_b_i,
  input  logic [31:0] dat_fwd_a_i,
  input  logic [31:0] dat_fwd_b_i,
  input  logic        fwd_stall_i,
  input  logic        ex_stall_i,
  input  logic        flush_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_dat_i,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_inst_o,
  output logic [31:0] ex_rs1_dat_o,
  output logic [31:0] ex_rs2_dat_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rd_o,
  output logic [1:0]  ex_inst_class_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_EX   = 2'b01;
  localparam logic [1:0] CLS_MEM  = 2'b10;

  function automatic logic signed [31:0] gen_imm(input logic [31:0] inst);
    logic signed [31:0] imm;
    imm = '0;
    case (inst[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

  // x0 outranks forwarding, forwarding outranks the write-through bypass.
  function automatic logic [31:0] sel_operand(input logic [4:0]  idx,
                                              input logic        fwd,
                                              input logic [31:0] fwd_dat,
                                              input logic        we,
                                              input logic [4:0]  wrd,
                                              input logic [31:0] wdat,
                                              input logic [31:0] arr_dat);
    logic [31:0] res;
    if (idx == 5'd0)
      res = '0;
    else if (fwd)
      res = fwd_dat;
    else if (we && (wrd == idx))
      res = wdat;
    else
      res = arr_dat;
    return res;
  endfunction

  logic [31:0]        rf [32];
  logic               uses_rs1;
  logic               uses_rs2;
  logic [1:0]         raw_cls;
  logic [4:0]         dec_rd;
  logic [1:0]         dec_cls;
  logic signed [31:0] dec_imm;
  logic [31:0]        opnd_a;
  logic [31:0]        opnd_b;
  logic               load_en;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    raw_cls  = CLS_NONE;
    case (if_inst_i[6:0])
      OPC_OP:                      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; raw_cls = CLS_EX; end
      OPC_OPIMM, OPC_JALR:         begin uses_rs1 = 1'b1; raw_cls = CLS_EX; end
      OPC_LOAD:                    begin uses_rs1 = 1'b1; raw_cls = CLS_MEM; end
      OPC_STORE, OPC_BRANCH:       begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_LUI, OPC_AUIPC, OPC_JAL: raw_cls = CLS_EX;
      default:                     raw_cls = CLS_NONE;
    endcase
  end

  // Unused indices read as x0 so they can never match in the forwarding unit.
  assign rs1_o   = (if_valid_i && uses_rs1) ? if_inst_i[19:15] : 5'd0;
  assign rs2_o   = (if_valid_i && uses_rs2) ? if_inst_i[24:20] : 5'd0;
  assign dec_rd  = (raw_cls != CLS_NONE) ? if_inst_i[11:7] : 5'd0;
  assign dec_cls = (dec_rd == 5'd0) ? CLS_NONE : raw_cls;
  assign dec_imm = gen_imm(if_inst_i);

  assign opnd_a = sel_operand(rs1_o, is_fwd_a_i, dat_fwd_a_i, wb_we_i, wb_rd_i, wb_dat_i, rf[rs1_o]);
  assign opnd_b = sel_operand(rs2_o, is_fwd_b_i, dat_fwd_b_i, wb_we_i, wb_rd_i, wb_dat_i, rf[rs2_o]);

  // A flushed instruction is consumed (and discarded) even under a hold.
  assign id_ready_o = (!ex_stall_i && !(fwd_stall_i && if_valid_i)) || flush_i;
  assign load_en    = if_valid_i && !fwd_stall_i;

  // Register file: entry 0 is never written and always reads 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we_i && (wb_rd_i != 5'd0)) begin
      rf[wb_rd_i] <= wb_dat_i;
    end
  end

  // ---- ID/EX boundary ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_o      <= 1'b0;
      ex_pc_o         <= '0;
      ex_inst_o       <= NOP_INST;
      ex_rs1_dat_o    <= '0;
      ex_rs2_dat_o    <= '0;
      ex_imm_o        <= '0;
      ex_rd_o         <= '0;
      ex_inst_class_o <= CLS_NONE;
    end else if (flush_i || (!ex_stall_i && !load_en)) begin
      ex_valid_o      <= 1'b0;
      ex_pc_o         <= '0;
      ex_inst_o       <= NOP_INST;
      ex_rs1_dat_o    <= '0;
      ex_rs2_dat_o    <= '0;
      ex_imm_o        <= '0;
      ex_rd_o         <= '0;
      ex_inst_class_o <= CLS_NONE;
    end else if (!ex_stall_i) begin
      ex_valid_o      <= 1'b1;
      ex_pc_o         <= if_pc_i;
      ex_inst_o       <= if_inst_i;
      ex_rs1_dat_o    <= opnd_a;
      ex_rs2_dat_o    <= opnd_b;
      ex_imm_o        <= dec_imm;
      ex_rd_o         <= dec_rd;
      ex_inst_class_o <= dec_cls;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  rs1, rs2;
  logic        fwd_a, fwd_b;
  logic [31:0] fdat_a, fdat_b;
  logic        fwd_stall, ex_stall, flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_dat;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_inst, ex_rs1_dat, ex_rs2_dat, ex_imm;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_cls;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_valid_i(if_valid), .if_inst_i(if_inst), .if_pc_i(if_pc),
    .id_ready_o(id_ready), .rs1_o(rs1), .rs2_o(rs2),
    .is_fwd_a_i(fwd_a), .is_fwd_b_i(fwd_b),
    .dat_fwd_a_i(fdat_a), .dat_fwd_b_i(fdat_b),
    .fwd_stall_i(fwd_stall), .ex_stall_i(ex_stall), .flush_i(flush),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_dat_i(wb_dat),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_inst_o(ex_inst),
    .ex_rs1_dat_o(ex_rs1_dat), .ex_rs2_dat_o(ex_rs2_dat), .ex_imm_o(ex_imm),
    .ex_rd_o(ex_rd), .ex_inst_class_o(ex_cls)
  );

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  cls;
    logic [31:0] imm;
  } dec_t;

  // Reference state
  logic [31:0] rf_m [32];
  logic        m_valid;
  logic [31:0] m_pc, m_inst, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd;
  logic [1:0]  m_cls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode straight from the ISA field layout, immediates built arithmetically.
  function automatic dec_t decode(input logic [31:0] inst, input logic v);
    dec_t d;
    byte  fmt;
    int   sgn;
    int   imm;
    d   = '0;
    fmt = "N";
    case (inst[6:0])
      7'h33:               fmt = "R";
      7'h03, 7'h13, 7'h67: fmt = "I";
      7'h23:               fmt = "S";
      7'h63:               fmt = "B";
      7'h37, 7'h17:        fmt = "U";
      7'h6F:               fmt = "J";
      default:             fmt = "N";
    endcase
    sgn = inst[31] ? -1 : 0;
    case (fmt)
      "I": imm = sgn * 2048 + int'(inst[30:20]);
      "S": imm = sgn * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:7]);
      "B": imm = sgn * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
      "U": imm = int'(inst & 32'hFFFF_F000);
      "J": imm = sgn * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      default: imm = 0;
    endcase
    d.imm = imm;
    if (v && (fmt inside {"R", "I", "S", "B"})) d.rs1 = inst[19:15];
    if (v && (fmt inside {"R", "S", "B"}))      d.rs2 = inst[24:20];
    if (inst[6:0] == 7'h03) d.cls = 2'b10;
    else if (inst[6:0] inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67}) d.cls = 2'b01;
    else d.cls = 2'b00;
    d.rd = (d.cls != 2'b00) ? inst[11:7] : 5'd0;
    if (d.rd == 5'd0) d.cls = 2'b00;
    return d;
  endfunction

  function automatic logic [31:0] m_opnd(input logic [4:0] idx, input logic f, input logic [31:0] fd);
    if (idx == 0) return 32'h0;
    if (f) return fd;
    if (wb_we && wb_rd == idx) return wb_dat;
    return rf_m[idx];
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0; m_pc = '0; m_inst = 32'h13; m_rs1 = '0; m_rs2 = '0;
    m_imm = '0; m_rd = '0; m_cls = '0;
  endtask

  task automatic model_reset();
    model_bubble();
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
  endtask

  task automatic idle();
    if_valid = 0; if_inst = '0; if_pc = '0; fwd_a = 0; fwd_b = 0;
    fdat_a = '0; fdat_b = '0; fwd_stall = 0; ex_stall = 0; flush = 0;
    wb_we = 0; wb_rd = '0; wb_dat = '0;
  endtask

  task automatic check_ex();
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_inst", ex_inst, m_inst);
    chk("ex_rs1_dat", ex_rs1_dat, m_rs1);
    chk("ex_rs2_dat", ex_rs2_dat, m_rs2);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
    chk("ex_cls", {30'b0, ex_cls}, {30'b0, m_cls});
  endtask

  // Check the combinational outputs, advance one edge, check ID/EX.
  task automatic tick();
    dec_t        d;
    logic [31:0] na, nb;
    logic        rdy;
    #1;
    d   = decode(if_inst, if_valid);
    rdy = (!ex_stall && !(fwd_stall && if_valid)) || flush;
    chk("rs1_o", {27'b0, rs1}, {27'b0, d.rs1});
    chk("rs2_o", {27'b0, rs2}, {27'b0, d.rs2});
    chk("id_ready", {31'b0, id_ready}, {31'b0, rdy});
    na = m_opnd(d.rs1, fwd_a, fdat_a);
    nb = m_opnd(d.rs2, fwd_b, fdat_b);
    @(posedge clk);
    #1;
    if (flush) model_bubble();
    else if (ex_stall) ;
    else if (!if_valid || fwd_stall) model_bubble();
    else begin
      m_valid = 1'b1; m_pc = if_pc; m_inst = if_inst; m_rs1 = na; m_rs2 = nb;
      m_imm = d.imm; m_rd = d.rd; m_cls = d.cls;
    end
    if (wb_we && wb_rd != 0) rf_m[wb_rd] = wb_dat;
    check_ex();
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1; if_inst = inst; if_pc = pc;
  endtask

  localparam logic [31:0] ADD_X6_X5 = 32'h0002_8333;  // add x6,x5,x0
  localparam logic [31:0] ADD_X6_X0 = 32'h0000_0333;  // add x6,x0,x0
  localparam logic [31:0] LW_X7     = 32'hFFC1_2383;  // lw x7,-4(x2)
  localparam logic [31:0] SW_X3     = 32'h0031_2423;  // sw x3,8(x2)
  localparam logic [31:0] BEQ_M8    = 32'hFE20_8CE3;  // beq x1,x2,-8
  localparam logic [31:0] LUI_X1    = 32'hABCD_E0B7;  // lui x1,0xABCDE

  logic [6:0] opc_tab [11];
  logic [31:0] rnd;

  initial begin
    opc_tab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F, 7'h00};
    idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_inst", ex_inst, 32'h13);
    chk("rst_rd", {27'b0, ex_rd}, 32'h0);
    @(posedge clk); #2 rst_n = 1;

    // Write x5, then read it back through an add.
    wb_we = 1; wb_rd = 5; wb_dat = 32'hDEAD_BEEF; tick();
    idle(); issue(ADD_X6_X5, 32'h100); tick();
    chk("wr_rd_rs1", ex_rs1_dat, 32'hDEAD_BEEF);
    chk("wr_rd_rd", {27'b0, ex_rd}, 32'd6);
    chk("wr_rd_cls", {30'b0, ex_cls}, 32'd1);

    // Same-cycle write and read.
    issue(ADD_X6_X5, 32'h104); wb_we = 1; wb_rd = 5; wb_dat = 32'h0BAD_F00D; tick();
    chk("bypass_rs1", ex_rs1_dat, 32'h0BAD_F00D);

    // Forwarding beats bypass; x0 beats forwarding.
    issue(ADD_X6_X5, 32'h108); fwd_a = 1; fdat_a = 32'h1234;
    wb_we = 1; wb_rd = 5; wb_dat = 32'h5678; tick();
    chk("fwd_prio", ex_rs1_dat, 32'h1234);
    idle(); issue(ADD_X6_X0, 32'h10C); fwd_a = 1; fdat_a = 32'h1234; tick();
    chk("fwd_x0", ex_rs1_dat, 32'h0);
    idle();

    issue(LW_X7, 32'h110); tick();
    chk("lw_imm", ex_imm, 32'hFFFF_FFFC);
    chk("lw_cls", {30'b0, ex_cls}, 32'd2);
    issue(SW_X3, 32'h114); tick();
    chk("sw_rd", {27'b0, ex_rd}, 32'd0);
    chk("sw_cls", {30'b0, ex_cls}, 32'd0);
    issue(BEQ_M8, 32'h118); tick();
    chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
    issue(LUI_X1, 32'h11C); #1;
    chk("lui_rs1", {27'b0, rs1}, 32'd0);
    chk("lui_rs2", {27'b0, rs2}, 32'd0);
    tick();
    chk("lui_imm", ex_imm, 32'hABCD_E000);

    // Load-use stall for two cycles.
    issue(ADD_X6_X5, 32'h120); fwd_stall = 1;
    tick(); chk("lu_bub1", {31'b0, ex_valid}, 32'd0);
    tick(); chk("lu_bub2", {31'b0, ex_valid}, 32'd0);
    fwd_stall = 0; tick();
    chk("lu_load", ex_inst, ADD_X6_X5);
    chk("lu_pc", ex_pc, 32'h120);

    // Downstream hold for three cycles, then flush during the hold.
    issue(LUI_X1, 32'h124); ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_inst", ex_inst, ADD_X6_X5);
    end
    flush = 1; tick();
    chk("flush_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_inst", ex_inst, 32'h13);

    // Reset in the middle of a stall.
    idle(); issue(LW_X7, 32'h200); tick();
    ex_stall = 1;
    #3 rst_n = 0;
    #1;
    chk("mrst_valid", {31'b0, ex_valid}, 32'd0);
    chk("mrst_inst", ex_inst, 32'h13);
    chk("mrst_rd", {27'b0, ex_rd}, 32'd0);
    chk("mrst_pc", ex_pc, 32'd0);
    model_reset();
    @(posedge clk); #2 rst_n = 1;
    idle(); issue(ADD_X6_X5, 32'h204); tick();
    chk("mrst_x5", ex_rs1_dat, 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rnd       = $urandom();
      if_inst   = {rnd[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   rnd[14:12], 5'($urandom_range(0, 7)), opc_tab[$urandom_range(0, 10)]};
      if_valid  = ($urandom_range(0, 9) != 0);
      if_pc     = $urandom() & 32'hFFFF_FFFC;
      fwd_a     = ($urandom_range(0, 5) == 0);
      fwd_b     = ($urandom_range(0, 5) == 0);
      fdat_a    = $urandom();
      fdat_b    = $urandom();
      fwd_stall = ($urandom_range(0, 7) == 0);
      ex_stall  = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      wb_we     = ($urandom_range(0, 1) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_dat    = $urandom();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
